// File: rtl/sciacc_ram_dma_pkg.sv
// sciacc_ram_dma_pkg
// Shared definitions for the response-FIFO-to-RAM write DMA:
//   - default parameter constants
//   - write FSM state encoding
package sciacc_ram_dma_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_FIFO_DEPTH = 16;
    localparam int DEF_LEN_WIDTH  = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_STROBE,
        ST_DONE
    } dma_state_e;

endpackage

// File: rtl/sciacc_ram_wr_dma_if.sv
// sciacc_ram_wr_dma_if
// Write port of the external RAM, as seen by the DMA.
//   master (DMA) : drives ram_wr_addr_l, ram_wr_data, CE_bar_l, RW_bar_l, OE_bar_l
//                  samples BUSY_bar_l, INTR_bar_l
//   slave  (RAM) : the reverse
// All strobes are active low.
interface sciacc_ram_wr_dma_if #(
    parameter int DATA_WIDTH = sciacc_ram_dma_pkg::DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = sciacc_ram_dma_pkg::DEF_ADDR_WIDTH
);
    logic [ADDR_WIDTH-1:0] ram_wr_addr_l;
    logic [DATA_WIDTH-1:0] ram_wr_data;
    logic                  CE_bar_l;
    logic                  RW_bar_l;
    logic                  OE_bar_l;
    logic                  BUSY_bar_l;
    logic                  INTR_bar_l;

    modport master (
        output ram_wr_addr_l, ram_wr_data, CE_bar_l, RW_bar_l, OE_bar_l,
        input  BUSY_bar_l, INTR_bar_l
    );

    modport slave (
        input  ram_wr_addr_l, ram_wr_data, CE_bar_l, RW_bar_l, OE_bar_l,
        output BUSY_bar_l, INTR_bar_l
    );
endinterface

// File: rtl/generic_fifo.sv
// generic_fifo
// Synchronous show-ahead FIFO: the head word is always visible on
// fifo_data_out while fifo_data_out_vld is high.
//   clk, reset          : clock, synchronous active-high reset
//   fifo_data_in/_push  : write port; a push while full is ignored
//   fifo_data_out_pop   : consume the head; ignored while empty
//   fifo_data_out/_vld  : head word and non-empty flag
//   fifo_full           : all FIFO_DEPTH entries occupied
module generic_fifo #(
    parameter int FIFO_DATA_WIDTH = 32,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [FIFO_DATA_WIDTH-1:0] fifo_data_in,
    input  logic                       fifo_data_in_push,
    input  logic                       fifo_data_out_pop,
    output logic [FIFO_DATA_WIDTH-1:0] fifo_data_out,
    output logic                       fifo_data_out_vld,
    output logic                       fifo_full
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [FIFO_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        push_ok, pop_ok;

    assign fifo_full         = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign fifo_data_out_vld = (wr_ptr_q != rd_ptr_q);
    assign fifo_data_out     = mem_q[rd_ptr_q[AW-1:0]];

    assign push_ok  = fifo_data_in_push & ~fifo_full;
    assign pop_ok   = fifo_data_out_pop & fifo_data_out_vld;
    assign wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
    assign rd_ptr_d = rd_ptr_q + (AW+1)'(pop_ok);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= fifo_data_in;
    end
endmodule

// File: rtl/sciacc_ram_wr_dma.sv
// sciacc_ram_wr_dma
// Buffers response words in a FIFO and writes a batch of them to
// consecutive RAM addresses, one CE/RW strobe per word, honouring the
// RAM's BUSY_bar_l back-pressure.
//   clk, reset                          : clock, synchronous active-high reset
//   fifo_data_in, fifo_data_in_push     : response word input
//   fifo_ready                          : FIFO not full
//   base_addr, batch_len, batch_start   : batch descriptor and start strobe
//   batch_busy, batch_done, batch_abort : batch status
//   overflow_err                        : sticky, a push hit a full FIFO
//   ram                                 : RAM write port (master modport)
// Build option: define SCIACC_RAM_WR_INTR_EN to let INTR_bar_l=0 abort a
// running batch (FIFO left unpopped). Undefined, INTR_bar_l is ignored.
module sciacc_ram_wr_dma
    import sciacc_ram_dma_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] fifo_data_in,
    input  logic                  fifo_data_in_push,
    output logic                  fifo_ready,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  batch_len,
    input  logic                  batch_start,
    output logic                  batch_busy,
    output logic                  batch_done,
    output logic                  batch_abort,
    output logic                  overflow_err,
    sciacc_ram_wr_dma_if.master   ram
);
    dma_state_e            state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  cnt_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic                  strobe_n_q;
    logic                  done_q, abort_q, ovf_q;

    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  fifo_vld, fifo_full, fifo_pop;
    logic                  intr_abort;

`ifdef SCIACC_RAM_WR_INTR_EN
    assign intr_abort = ~ram.INTR_bar_l;
`else
    logic unused_intr;
    assign unused_intr = ram.INTR_bar_l;
    assign intr_abort  = 1'b0;
`endif

    // Pop only on a completed write; an abort in the same cycle wins.
    assign fifo_pop = (state_q == ST_STROBE) && ram.BUSY_bar_l && !intr_abort;

    generic_fifo #(
        .FIFO_DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk               (clk),
        .reset             (reset),
        .fifo_data_in      (fifo_data_in),
        .fifo_data_in_push (fifo_data_in_push),
        .fifo_data_out_pop (fifo_pop),
        .fifo_data_out     (fifo_head),
        .fifo_data_out_vld (fifo_vld),
        .fifo_full         (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            strobe_n_q <= 1'b1;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            // The FIFO drops a push while full, even if it pops that cycle.
            ovf_q   <= ovf_q | (fifo_data_in_push & fifo_full);
            case (state_q)
                ST_IDLE: begin
                    if (batch_start) begin
                        addr_q  <= base_addr;
                        cnt_q   <= batch_len;
                        state_q <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (intr_abort) begin
                        done_q  <= 1'b1;
                        abort_q <= 1'b1;
                        state_q <= ST_DONE;
                    end else if (cnt_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else if (fifo_vld) begin
                        wr_addr_q  <= addr_q;
                        wr_data_q  <= fifo_head;
                        strobe_n_q <= 1'b0;
                        state_q    <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    if (intr_abort) begin
                        strobe_n_q <= 1'b1;
                        done_q     <= 1'b1;
                        abort_q    <= 1'b1;
                        state_q    <= ST_DONE;
                    end else if (ram.BUSY_bar_l) begin
                        strobe_n_q <= 1'b1;
                        addr_q     <= addr_q + ADDR_WIDTH'(1);
                        cnt_q      <= cnt_q - LEN_WIDTH'(1);
                        state_q    <= ST_WRITE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign fifo_ready        = ~fifo_full;
    assign batch_busy        = (state_q != ST_IDLE);
    assign batch_done        = done_q;
    assign batch_abort       = abort_q;
    assign overflow_err      = ovf_q;
    assign ram.ram_wr_addr_l = wr_addr_q;
    assign ram.ram_wr_data   = wr_data_q;
    assign ram.CE_bar_l      = strobe_n_q;
    assign ram.RW_bar_l      = strobe_n_q;
    assign ram.OE_bar_l      = 1'b1;
endmodule

// File: tb/tb_sciacc_ram_wr_dma.sv
// tb_sciacc_ram_wr_dma
// Table-driven batches, randomized batches against a queue model of the
// FIFO and RAM address sequence, plus hand-written reset, overflow and
// (when SCIACC_RAM_WR_INTR_EN is defined) abort sequences.
module tb_sciacc_ram_wr_dma;
    localparam int DW    = 32;
    localparam int AW    = 12;
    localparam int DEPTH = 16;
    localparam int LW    = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] fifo_data_in;
    logic          fifo_data_in_push;
    logic          fifo_ready;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] batch_len;
    logic          batch_start;
    logic          batch_busy, batch_done, batch_abort, overflow_err;

    always #5 clk = ~clk;

    sciacc_ram_wr_dma_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ram ();

    sciacc_ram_wr_dma #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .LEN_WIDTH(LW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .fifo_data_in      (fifo_data_in),
        .fifo_data_in_push (fifo_data_in_push),
        .fifo_ready        (fifo_ready),
        .base_addr         (base_addr),
        .batch_len         (batch_len),
        .batch_start       (batch_start),
        .batch_busy        (batch_busy),
        .batch_done        (batch_done),
        .batch_abort       (batch_abort),
        .overflow_err      (overflow_err),
        .ram               (ram)
    );

    typedef struct {
        logic [AW-1:0] base;
        int            len;
        int            npush;
        int            st_word;   // index within batch to stall, -1 none
        int            st_cyc;    // BUSY_bar_l=0 cycles on that word
        int            exp_n;
        logic [AW-1:0] exp_last;
        int            exp_lat;   // 0 = not checked
    } vec_t;

    int tests = 0;
    int fails = 0;

    // Reference model: words the FIFO should hold, in order.
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] next_data = 32'hA0;

    // Monitor state (written only by the monitor process).
    logic [AW-1:0] wa_q[$];
    logic [DW-1:0] wd_q[$];
    int            wh_q[$];
    int            widx = 0, hold = 0, held_bad = 0, oe_bad = 0;
    int            done_cnt = 0, abort_cnt = 0;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_data;
    // Stall control (written only by the initial process).
    int            stall_word = -1, stall_cyc = 0;

    // RAM-side responder: decides BUSY_bar_l for the coming edge and
    // records every write that completes.
    always @(negedge clk) begin
        if (ram.OE_bar_l !== 1'b1) oe_bad++;
        if (batch_done === 1'b1) done_cnt++;
        if (batch_abort === 1'b1) abort_cnt++;
        if (ram.CE_bar_l === 1'b0 && ram.RW_bar_l === 1'b0) begin
            hold++;
            if (hold == 1) begin
                h_addr = ram.ram_wr_addr_l;
                h_data = ram.ram_wr_data;
            end else if (ram.ram_wr_addr_l !== h_addr || ram.ram_wr_data !== h_data) begin
                held_bad++;
            end
            if (widx == stall_word && hold <= stall_cyc) begin
                ram.BUSY_bar_l = 1'b0;
            end else begin
                ram.BUSY_bar_l = 1'b1;
                wa_q.push_back(ram.ram_wr_addr_l);
                wd_q.push_back(ram.ram_wr_data);
                wh_q.push_back(hold);
                widx++;
                hold = 0;
            end
        end else begin
            hold = 0;
            ram.BUSY_bar_l = 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic push_word();
        @(posedge clk);
        #1;
        fifo_data_in      = next_data;
        fifo_data_in_push = 1'b1;
        if (model_q.size() < DEPTH) model_q.push_back(next_data);
        next_data = next_data + 1;
        @(posedge clk);
        #1;
        fifo_data_in_push = 1'b0;
    endtask

    task automatic start_batch(input logic [AW-1:0] b, input int len);
        @(posedge clk);
        #1;
        base_addr   = b;
        batch_len   = LW'(len);
        batch_start = 1'b1;
        @(posedge clk);
        #1;
        batch_start = 1'b0;
    endtask

    task automatic run_batch(input vec_t v);
        int w0, d0, a0, lat, got;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        for (int i = 0; i < v.npush; i++) push_word();
        w0 = wa_q.size();
        d0 = done_cnt;
        a0 = abort_cnt;
        stall_word = (v.st_word >= 0) ? w0 + v.st_word : -1;
        stall_cyc  = v.st_cyc;
        start_batch(v.base, v.len);
        got = 0;
        lat = 0;
        for (int c = 1; c <= 2000 && got == 0; c++) begin
            @(negedge clk);
            if (batch_done === 1'b1) begin
                got = 1;
                lat = c;
            end
        end
        chk("done_seen", 64'(got), 64'd1);
        if (v.exp_lat > 0) chk("done_latency", 64'(lat), 64'(v.exp_lat));
        @(posedge clk);
        #1;
        chk("busy_after_done", {63'd0, batch_busy}, 64'd0);
        chk("done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("abort_pulses", 64'(abort_cnt - a0), 64'd0);
        chk("write_count", 64'(wa_q.size() - w0), 64'(v.exp_n));
        ea = v.base;
        for (int i = 0; i < v.exp_n && (w0 + i) < wa_q.size(); i++) begin
            ed = model_q.pop_front();
            chk("wr_addr", 64'(wa_q[w0+i]), 64'(ea));
            chk("wr_data", 64'(wd_q[w0+i]), 64'(ed));
            chk("strobe_len", 64'(wh_q[w0+i]), (i == v.st_word) ? 64'(v.st_cyc + 1) : 64'd1);
            ea = ea + 1'b1;
        end
        if (v.exp_n > 0) chk("last_addr", 64'(wa_q[w0+v.exp_n-1]), 64'(v.exp_last));
        stall_word = -1;
    endtask

    vec_t tbl[6];
    vec_t rv;

    initial begin
        tbl[0] = '{12'h010, 4, 4, -1, 0, 4, 12'h013, 0};
        tbl[1] = '{12'hFFE, 3, 3, -1, 0, 3, 12'h000, 0};
        tbl[2] = '{12'h100, 4, 4,  1, 3, 4, 12'h103, 0};
        tbl[3] = '{12'h020, 0, 0, -1, 0, 0, 12'h000, 2};
        tbl[4] = '{12'h7FF, 2, 5, -1, 0, 2, 12'h800, 0};
        tbl[5] = '{12'h300, 3, 0, -1, 0, 3, 12'h302, 0};

        reset             = 1'b1;
        fifo_data_in      = '0;
        fifo_data_in_push = 1'b0;
        base_addr         = '0;
        batch_len         = '0;
        batch_start       = 1'b0;
        ram.INTR_bar_l    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_busy",  {63'd0, batch_busy},   64'd0);
        chk("rst_done",  {63'd0, batch_done},   64'd0);
        chk("rst_abort", {63'd0, batch_abort},  64'd0);
        chk("rst_ovf",   {63'd0, overflow_err}, 64'd0);
        chk("rst_ready", {63'd0, fifo_ready},   64'd1);
        chk("rst_ce",    {63'd0, ram.CE_bar_l}, 64'd1);
        chk("rst_rw",    {63'd0, ram.RW_bar_l}, 64'd1);
        chk("rst_oe",    {63'd0, ram.OE_bar_l}, 64'd1);
        chk("rst_addr",  64'(ram.ram_wr_addr_l), 64'd0);
        chk("rst_data",  64'(ram.ram_wr_data),   64'd0);

        foreach (tbl[i]) run_batch(tbl[i]);

        for (int it = 0; it < 30; it++) begin
            rv.base    = AW'($urandom_range(0, 4095));
            rv.npush   = $urandom_range(0, DEPTH - model_q.size());
            rv.len     = $urandom_range(0, model_q.size() + rv.npush);
            rv.st_word = (rv.len > 0) ? $urandom_range(0, rv.len - 1) : -1;
            rv.st_cyc  = $urandom_range(0, 3);
            rv.exp_n   = rv.len;
            rv.exp_last = rv.base + AW'(rv.len) - 1'b1;
            rv.exp_lat = 0;
            run_batch(rv);
        end
        if (model_q.size() > 0) begin
            rv = '{12'h200, model_q.size(), 0, -1, 0, model_q.size(), 12'h200 + AW'(model_q.size()) - 1'b1, 0};
            run_batch(rv);
        end
        chk("strobe_held", 64'(held_bad), 64'd0);
        chk("oe_const", 64'(oe_bad), 64'd0);

`ifdef SCIACC_RAM_WR_INTR_EN
        begin : abort_seq
            int w0, got, ab;
            for (int i = 0; i < 8; i++) push_word();
            w0 = wa_q.size();
            start_batch(12'h040, 8);
            for (int c = 0; c < 200 && wa_q.size() < w0 + 2; c++) begin
                @(negedge clk);
                #1;
            end
            chk("abort_two_written", 64'(wa_q.size() - w0), 64'd2);
            @(posedge clk);
            #1;
            ram.INTR_bar_l = 1'b0;
            got = 0;
            ab  = 0;
            for (int c = 0; c < 50 && got == 0; c++) begin
                @(negedge clk);
                if (batch_done === 1'b1) begin
                    got = 1;
                    ab  = (batch_abort === 1'b1) ? 1 : 0;
                end
            end
            ram.INTR_bar_l = 1'b1;
            chk("abort_done", 64'(got), 64'd1);
            chk("abort_with_done", 64'(ab), 64'd1);
            @(posedge clk);
            #1;
            chk("abort_writes", 64'(wa_q.size() - w0), 64'd2);
            void'(model_q.pop_front());
            void'(model_q.pop_front());
            rv = '{12'h080, 6, 0, -1, 0, 6, 12'h085, 0};
            run_batch(rv);
        end
`endif

        // Reset in the middle of a stalled batch.
        begin : reset_seq
            int d0;
            for (int i = 0; i < 3; i++) push_word();
            stall_word = wa_q.size();
            stall_cyc  = 1000;
            start_batch(12'h050, 3);
            repeat (5) @(posedge clk);
            #1;
            chk("mid_busy", {63'd0, batch_busy}, 64'd1);
            d0 = done_cnt;
            reset = 1'b1;
            @(posedge clk);
            #1;
            reset = 1'b0;
            stall_word = -1;
            model_q.delete();
            chk("mid_rst_busy",  {63'd0, batch_busy},   64'd0);
            chk("mid_rst_ce",    {63'd0, ram.CE_bar_l}, 64'd1);
            chk("mid_rst_ready", {63'd0, fifo_ready},   64'd1);
            chk("mid_rst_addr",  64'(ram.ram_wr_addr_l), 64'd0);
            repeat (5) @(posedge clk);
            #1;
            chk("mid_rst_no_done", 64'(done_cnt - d0), 64'd0);
        end

        // Overflow: FIFO must be empty after the reset, so exactly 16 fit.
        for (int i = 0; i < DEPTH; i++) begin
            push_word();
            if (i == DEPTH - 2) chk("ovf_ready_15", {63'd0, fifo_ready}, 64'd1);
        end
        chk("ovf_ready_16", {63'd0, fifo_ready}, 64'd0);
        chk("ovf_before", {63'd0, overflow_err}, 64'd0);
        push_word();
        chk("ovf_set", {63'd0, overflow_err}, 64'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("ovf_sticky", {63'd0, overflow_err}, 64'd1);
        rv = '{12'h400, DEPTH, 0, -1, 0, DEPTH, 12'h40F, 0};
        run_batch(rv);
        chk("ovf_after_drain", {63'd0, overflow_err}, 64'd1);
        chk("ready_after_drain", {63'd0, fifo_ready}, 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("ovf_cleared", {63'd0, overflow_err}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
